// File: rtl/mac_pipe_acc.sv
// ============================================================================
// Module      : mac_pipe_acc
// Description : Two-stage pipelined unsigned multiply-accumulate over
//               dot-product vectors with valid/ready handshake on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_pipe_acc #(
  parameter int DW    = 4,
  parameter int ACC_W = 12,
  parameter int SAT   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_a,
  input  logic [DW-1:0]    in_b,
  input  logic [ACC_W-1:0] in_c,
  input  logic             in_first,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_result,
  output logic             out_cout
);

  localparam int c_PW = 2 * DW;

  if (ACC_W < c_PW) begin : g_bad_width
    $error("mac_pipe_acc: ACC_W must be at least 2*DW");
  end

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic             w_stall;
  logic             w_accept;
  logic             w_first_eff;
  logic [ACC_W-1:0] w_seed;
  logic [c_PW-1:0]  w_prod;

  // S1 registers
  logic             r_s1_valid;
  logic             r_s1_first;
  logic             r_s1_last;
  logic [ACC_W-1:0] r_s1_seed;
  logic [c_PW-1:0]  r_s1_prod;

  // S2 registers
  logic             r_s2_valid;
  logic             r_s2_last;
  logic [ACC_W-1:0] r_acc;
  logic             r_flag;

  // output registers
  logic             r_out_valid;
  logic [ACC_W-1:0] r_out_result;
  logic             r_out_cout;

  logic [ACC_W-1:0] w_base;
  logic [ACC_W:0]   w_sum;
  logic             w_carry;
  logic [ACC_W-1:0] w_acc_nxt;
  logic             w_flag_nxt;

  // The whole pipeline freezes while a finished result waits for the consumer.
  assign w_stall     = r_out_valid & ~out_ready;
  assign in_ready    = ~rst & ~w_stall;
  assign w_accept    = in_valid & in_ready;
  assign w_first_eff = in_first | (r_state == ST_IDLE);
  assign w_seed      = in_first ? in_c : '0;
  assign w_prod      = {{DW{1'b0}}, in_a} * {{DW{1'b0}}, in_b};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else if (!w_stall) begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      w_state_nxt = in_last ? ST_IDLE : ST_ACC;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_seed  <= '0;
      r_s1_prod  <= '0;
    end else if (!w_stall) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_first <= w_first_eff;
        r_s1_last  <= in_last;
        r_s1_seed  <= w_seed;
        r_s1_prod  <= w_prod;
      end
    end
  end

  assign w_base     = r_s1_first ? r_s1_seed : r_acc;
  assign w_sum      = {1'b0, w_base} + {1'b0, ACC_W'(r_s1_prod)};
  assign w_carry    = w_sum[ACC_W];
  assign w_flag_nxt = w_carry | (~r_s1_first & r_flag);

  // Once saturated, any further non-zero product carries again, so the
  // accumulator stays pinned at all-ones until the vector ends.
  if (SAT != 0) begin : g_sat
    assign w_acc_nxt = w_carry ? '1 : w_sum[ACC_W-1:0];
  end else begin : g_wrap
    assign w_acc_nxt = w_sum[ACC_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_last  <= 1'b0;
      r_acc      <= '0;
      r_flag     <= 1'b0;
    end else if (!w_stall) begin
      r_s2_valid <= r_s1_valid;
      r_s2_last  <= r_s1_last;
      if (r_s1_valid) begin
        r_acc  <= w_acc_nxt;
        r_flag <= w_flag_nxt;
      end
    end
  end

  // Without a stall, a valid output is being taken this cycle, so it either
  // reloads from a completing vector or drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_cout   <= 1'b0;
    end else if (!w_stall) begin
      if (r_s2_valid && r_s2_last) begin
        r_out_valid  <= 1'b1;
        r_out_result <= r_acc;
        r_out_cout   <= r_flag;
      end else begin
        r_out_valid  <= 1'b0;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_cout   = r_out_cout;

endmodule

`default_nettype wire

// File: doc/mac_pipe_acc.md
MAC_PIPE_ACC -- requirements
Module: mac_pipe_acc

Interface
REQ-001 Parameter DW, default 4: operand width of in_a and in_b, in bits.
REQ-002 Parameter ACC_W, default 12: accumulator and result width; ACC_W >= 2*DW shall be checked at elaboration.
REQ-003 Parameter SAT, default 0: overflow policy; 0 = wrap modulo 2^ACC_W, 1 = saturate to all-ones.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 in_valid  input  1  input beat present.
REQ-007 in_ready  output  1  block accepts a beat this cycle; a beat transfers when in_valid & in_ready.
REQ-008 in_a  input  DW  unsigned multiplicand.
REQ-009 in_b  input  DW  unsigned multiplier.
REQ-010 in_c  input  ACC_W  unsigned accumulator seed, sampled only on a beat with in_first=1.
REQ-011 in_first  input  1  beat starts a new dot-product vector.
REQ-012 in_last  input  1  beat ends the current vector.
REQ-013 out_valid  output  1  result available.
REQ-014 out_ready  input  1  consumer accepts the result; a result transfers when out_valid & out_ready.
REQ-015 out_result  output  ACC_W  seed plus sum of a*b over the vector, after the SAT policy.
REQ-016 out_cout  output  1  sticky overflow: any carry out of bit ACC_W-1 during the vector.

Function
REQ-017 Datapath shall have 2 pipeline stages: S1 registers the 2*DW-bit product a*b together with first, last and seed; S2 adds the zero-extended product into the accumulator.
REQ-018 S2 on a first beat: acc = seed + P and overflow flag = carry; on any other beat: acc = acc + P and flag = flag | carry.
REQ-019 SAT=0: acc keeps the low ACC_W bits of the sum; SAT=1: on carry, acc = 2^ACC_W-1, and it stays there for the rest of the vector.
REQ-020 Input-side FSM states: IDLE (no vector open) and ACC (vector open); IDLE->ACC on an accepted non-last beat; ACC->IDLE on an accepted last beat; otherwise state holds.
REQ-021 A beat accepted in IDLE with in_first=0 shall be treated as first with seed 0.
REQ-022 A beat with in_first=1 accepted in ACC shall discard the partial sum and restart with seed in_c.
REQ-023 A beat with in_first=1 and in_last=1 shall form a complete 1-beat vector.
REQ-024 When a last beat leaves S2, out_result and out_cout shall load from acc and the flag, and out_valid shall rise.
REQ-025 Latency: a last beat accepted at edge t shall give out_valid=1 after edge t+2 when there is no stall.
REQ-026 stall = out_valid & ~out_ready; under stall, S1, S2 and the FSM shall hold and in_ready shall be 0.
REQ-027 in_ready = ~rst & ~stall (combinational); throughput is 1 beat per cycle when out_ready=1.
REQ-028 out_valid shall fall after a transfer unless a new last beat completes in the same cycle, in which case the new result shall load and out_valid shall stay 1.
REQ-029 out_result and out_cout shall stay stable while out_valid=1 and out_ready=0.
REQ-030 Bubbles (in_valid=0) shall advance the pipeline without changing acc.

Reset
REQ-031 While rst=1 at an edge, every register shall clear: FSM=IDLE, S1/S2 valid=0, acc=0, flag=0, out_valid=0, out_result=0, out_cout=0.
REQ-032 Reset asserted mid-vector shall discard the partial sum and any in-flight beats; no result shall be produced for that vector.
REQ-033 in_ready shall be 0 while rst=1 and 1 on the first cycle after release.

Verification (DW=4, ACC_W=12 unless stated)
REQ-034 SAT=0, one beat first=last=1, a=15, b=15, c=4095 -> out_result=224, out_cout=1, out_valid 2 cycles after acceptance.
REQ-035 SAT=0, 4 back-to-back beats, c=10, (a,b) = (3,5), (7,2), (15,15), (1,1) -> out_result=265, out_cout=0, exactly one out_valid pulse.
REQ-036 SAT=1, c=4000, two beats (15,15), (15,15) -> out_result=4095, out_cout=1.
REQ-037 Backpressure: out_ready=0 held 5 cycles with a second vector pending -> in_ready=0, out_result stable, no beat lost; after release both results appear in order.
REQ-038 Reset mid-vector after 2 beats, then one beat (1,1), c=0, first=last=1 -> out_result=1, out_cout=0, no stale result.
REQ-039 in_first=1 on the 3rd beat of an open vector with c=7, (2,3) last -> out_result=13.
